// File: rtl/sid_bus_regs.sv
// sid_bus_regs: SID register file and bus-protocol stage behind the pad I/O block.
// It commits writes to the 25 write-only registers and muxes the registered read byte.
// It also models the leaked data-bus value that decays after BUS_TTL phi2 falling edges.
module sid_bus_regs #(
  parameter int unsigned      TTL_W   = 14,
  parameter logic [TTL_W-1:0] BUS_TTL = TTL_W'(14'h2000)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         phi2,
  input  logic         bus_we,
  input  logic         bus_oe,
  input  logic         bus_res,
  input  logic [4:0]   bus_addr,
  input  logic [7:0]   bus_data,
  input  logic         cs_n,
  input  logic [7:0]   pot_x,
  input  logic [7:0]   pot_y,
  input  logic [7:0]   osc3,
  input  logic [7:0]   env3,
  output logic [199:0] regs_o,
  output logic         wr_stb,
  output logic [4:0]   wr_addr,
  output logic [7:0]   wr_data,
  output logic [7:0]   data_o
);

  localparam int unsigned NREGS = 25;
  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 5;
  localparam int unsigned RW    = NREGS * DW;

  logic [RW-1:0]    regs_q, regs_d;
  logic             wr_stb_q, wr_stb_d;
  logic [AW-1:0]    wr_addr_q, wr_addr_d;
  logic [DW-1:0]    wr_data_q, wr_data_d;
  logic [DW-1:0]    data_o_q, data_o_d;
  logic [DW-1:0]    bus_value_q, bus_value_d;
  logic [TTL_W-1:0] ttl_q, ttl_d;
  logic             we_q, phi2_q, rd_q;

  logic            commit, rd, rd_edge, phi2_fall, ro_addr;
  logic [DW-1:0]   mux_val;

  // Strobe decode: write commit on bus_we fall, read edge, phi2 fall.
  always_comb begin
    commit    = we_q & ~bus_we & ~cs_n;
    rd        = bus_oe & ~cs_n;
    rd_edge   = rd & ~rd_q;
    phi2_fall = phi2_q & ~phi2;
    ro_addr   = (bus_addr >= AW'(5'h19)) && (bus_addr <= AW'(5'h1C));
  end

  // Read mux: readback registers, otherwise the leaked bus value.
  always_comb begin
    mux_val = bus_value_q;
    case (bus_addr)
      AW'(5'h19): mux_val = pot_x;
      AW'(5'h1A): mux_val = pot_y;
      AW'(5'h1B): mux_val = osc3;
      AW'(5'h1C): mux_val = env3;
      default:    mux_val = bus_value_q;
    endcase
  end

  // Next-state: register commit, bus-value reload (commit beats read) and decay.
  always_comb begin
    regs_d      = regs_q;
    wr_stb_d    = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    data_o_d    = data_o_q;
    bus_value_d = bus_value_q;
    ttl_d       = ttl_q;

    if (commit) begin
      wr_stb_d    = 1'b1;
      wr_addr_d   = bus_addr;
      wr_data_d   = bus_data;
      bus_value_d = bus_data;
      ttl_d       = BUS_TTL;
      for (int i = 0; i < NREGS; i++) begin
        if (bus_addr == AW'(i)) regs_d[DW*i +: DW] = bus_data;
      end
    end else if (rd_edge && ro_addr) begin
      bus_value_d = mux_val;
      ttl_d       = BUS_TTL;
    end else if (phi2_fall && (ttl_q != '0)) begin
      ttl_d = ttl_q - TTL_W'(1);
      if (ttl_q == TTL_W'(1)) bus_value_d = '0;
    end

    if (rd) data_o_d = mux_val;
  end

  // State registers; SID /RES acts as an extra synchronous reset.
  always_ff @(posedge clk) begin
    if (rst | bus_res) begin
      regs_q      <= '0;
      wr_stb_q    <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      data_o_q    <= '0;
      bus_value_q <= '0;
      ttl_q       <= '0;
      we_q        <= 1'b0;
      phi2_q      <= 1'b0;
      rd_q        <= 1'b0;
    end else begin
      regs_q      <= regs_d;
      wr_stb_q    <= wr_stb_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      data_o_q    <= data_o_d;
      bus_value_q <= bus_value_d;
      ttl_q       <= ttl_d;
      we_q        <= bus_we;
      phi2_q      <= phi2;
      rd_q        <= rd;
    end
  end

  assign regs_o  = regs_q;
  assign wr_stb  = wr_stb_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign data_o  = data_o_q;

endmodule

// File: tb/tb_sid_bus_regs.sv
// tb_sid_bus_regs: scoreboard bench for sid_bus_regs with a register/bus-value reference model.
module tb_sid_bus_regs;

  localparam logic [13:0] T = 14'd24;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         phi2 = 1'b0;
  logic         bus_we = 1'b0;
  logic         bus_oe = 1'b0;
  logic         bus_res = 1'b0;
  logic [4:0]   bus_addr = '0;
  logic [7:0]   bus_data = '0;
  logic         cs_n = 1'b1;
  logic [7:0]   pot_x = '0, pot_y = '0, osc3 = '0, env3 = '0;
  logic [199:0] regs_o;
  logic         wr_stb;
  logic [4:0]   wr_addr;
  logic [7:0]   wr_data;
  logic [7:0]   data_o;

  sid_bus_regs #(.TTL_W(14), .BUS_TTL(T)) dut (
    .clk(clk), .rst(rst), .phi2(phi2), .bus_we(bus_we), .bus_oe(bus_oe),
    .bus_res(bus_res), .bus_addr(bus_addr), .bus_data(bus_data), .cs_n(cs_n),
    .pot_x(pot_x), .pot_y(pot_y), .osc3(osc3), .env3(env3),
    .regs_o(regs_o), .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data),
    .data_o(data_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: register contents, leaked bus byte and its remaining lifetime.
  logic [7:0] m_regs [25];
  logic [7:0] m_bus = '0;
  int         m_ttl = 0;

  typedef struct packed {
    logic [4:0]   a;
    logic [7:0]   d;
    logic [199:0] r;
  } wr_exp_t;

  wr_exp_t    wr_q [$];
  logic [7:0] rd_exp_q [$];
  logic       rd_at_edge = 1'b0;

  task automatic chk(input string name, input logic [199:0] act, input logic [199:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [199:0] pack_regs();
    logic [199:0] r;
    for (int i = 0; i < 25; i++) r[8*i +: 8] = m_regs[i];
    return r;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 25; i++) m_regs[i] = 8'h00;
    m_bus = 8'h00;
    m_ttl = 0;
  endfunction

  function automatic void model_fall();
    if (m_ttl > 0) begin
      m_ttl--;
      if (m_ttl == 0) m_bus = 8'h00;
    end
  endfunction

  function automatic logic [7:0] model_read(input logic [4:0] a);
    case (a)
      5'h19:   return pot_x;
      5'h1A:   return pot_y;
      5'h1B:   return osc3;
      5'h1C:   return env3;
      default: return m_bus;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Write cycle; with fall=1 the phi2 falling edge lands on the commit clock.
  task automatic wr(input logic [4:0] a, input logic [7:0] d, input logic csn, input bit fall);
    wr_exp_t e;
    step();
    bus_addr = a; bus_data = d; cs_n = csn; bus_we = 1'b1;
    if (fall) phi2 = 1'b1;
    step();
    bus_we = 1'b0;
    if (fall) phi2 = 1'b0;
    if (!csn) begin
      m_bus = d;
      m_ttl = int'(T);
      if (a <= 5'd24) m_regs[a] = d;
      e.a = a; e.d = d; e.r = pack_regs();
      wr_q.push_back(e);
    end else if (fall) begin
      model_fall();
    end
    step();
    cs_n = 1'b1;
  endtask

  // Single-clock read pulse.
  task automatic rd(input logic [4:0] a);
    logic [7:0] v;
    step();
    bus_addr = a; cs_n = 1'b0; bus_oe = 1'b1;
    v = model_read(a);
    if (a >= 5'h19 && a <= 5'h1C) begin
      m_bus = v;
      m_ttl = int'(T);
    end
    rd_exp_q.push_back(v);
    step();
    bus_oe = 1'b0; cs_n = 1'b1;
  endtask

  task automatic falls(input int n);
    repeat (n) begin
      step(); phi2 = 1'b1;
      step(); phi2 = 1'b0;
      model_fall();
    end
  endtask

  // Reset pulse; optionally a write strobe is high during reset and falls on release.
  task automatic do_reset(input bit via_res, input bit we_during);
    step();
    if (via_res) bus_res = 1'b1; else rst = 1'b1;
    if (we_during) begin
      bus_we = 1'b1; cs_n = 1'b0; bus_addr = 5'h03; bus_data = 8'h99;
    end
    step();
    step();
    rst = 1'b0; bus_res = 1'b0; bus_we = 1'b0;
    model_clear();
    step();
    cs_n = 1'b1;
    chk("rst_regs_o", regs_o, 200'(0));
    chk("rst_data_o", 200'(data_o), 200'(0));
    chk("rst_wr_stb", 200'(wr_stb), 200'(0));
  endtask

  always @(posedge clk) rd_at_edge = bus_oe & ~cs_n;

  // Monitor: pops expected responses whenever the DUT presents a write strobe or read data.
  always @(negedge clk) begin
    wr_exp_t e;
    logic [7:0] v;
    if (wr_stb === 1'b1) begin
      if (wr_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL wr_stb_unexpected actual=1 expected=0 addr=%0h", wr_addr);
      end else begin
        e = wr_q.pop_front();
        chk("wr_addr", 200'(wr_addr), 200'(e.a));
        chk("wr_data", 200'(wr_data), 200'(e.d));
        chk("regs_o", regs_o, e.r);
      end
    end
    if (rd_at_edge === 1'b1) begin
      if (rd_exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL rd_unexpected actual=%0h expected=none", data_o);
      end else begin
        v = rd_exp_q.pop_front();
        chk("data_o", 200'(data_o), 200'(v));
      end
    end
  end

  initial begin
    model_clear();
    step(); step();
    rst = 1'b0;
    step();
    chk("init_regs_o", regs_o, 200'(0));
    chk("init_data_o", 200'(data_o), 200'(0));
    chk("init_wr_stb", 200'(wr_stb), 200'(0));
    chk("init_wr_addr", 200'(wr_addr), 200'(0));
    chk("init_wr_data", 200'(wr_data), 200'(0));

    // Highest register, then an unselected write that must leave everything alone.
    wr(5'h18, 8'h0F, 1'b0, 1'b0);
    wr(5'h05, 8'hA5, 1'b1, 1'b0);
    rd(5'h00);

    // Bus value survives BUS_TTL-1 falls and is gone after the last one.
    wr(5'h04, 8'h41, 1'b0, 1'b0);
    rd(5'h00);
    falls(int'(T) - 1);
    rd(5'h00);
    falls(1);
    rd(5'h00);

    // Readback reload of the bus value.
    pot_x = 8'h7E;
    rd(5'h19);
    rd(5'h1F);
    falls(int'(T) - 1);
    rd(5'h1F);
    falls(1);
    rd(5'h1F);

    // Write coinciding with the final decay fall: reload wins.
    wr(5'h00, 8'h11, 1'b0, 1'b0);
    falls(int'(T) - 1);
    wr(5'h07, 8'h5C, 1'b0, 1'b1);
    rd(5'h00);
    falls(int'(T) - 1);
    rd(5'h00);
    falls(1);
    rd(5'h00);

    // Fill all registers, then /RES with a write strobe in flight.
    for (int i = 0; i < 25; i++) wr(5'(i), 8'hFF, 1'b0, 1'b0);
    do_reset(1'b1, 1'b1);
    rd(5'h00);
    step(); step();

    // Randomized traffic.
    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 2))
        0: wr(5'($urandom_range(0, 31)), 8'($urandom), ($urandom_range(0, 5) == 0),
              ($urandom_range(0, 3) == 0));
        1: begin
          pot_x = 8'($urandom); pot_y = 8'($urandom);
          osc3  = 8'($urandom); env3  = 8'($urandom);
          rd(5'($urandom_range(0, 31)));
        end
        default: falls($urandom_range(0, 10));
      endcase
    end

    do_reset(1'b0, 1'b0);
    rd(5'h1F);
    repeat (4) step();
    chk("wr_queue_drained", 200'(wr_q.size()), 200'(0));
    chk("rd_queue_drained", 200'(rd_exp_q.size()), 200'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
